// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer scanout reader.
package fb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        ISSUE   = 3'd2,
        COLLECT = 3'd3,
        DISCARD = 3'd4
    } state_t;

    localparam int PIX_W  = 8;
    localparam int WORD_W = 16;

    // Two 8-bit pixels are packed into each 16-bit SDRAM word.
    function automatic int frame_words(input int h, input int v);
        return (h * v) / 2;
    endfunction

endpackage

// File: rtl/fb_scanout_reader_if.sv
// Avalon-MM burst read bus between the scanout reader (master) and the SDRAM port (slave).
interface fb_scanout_reader_if;
    import fb_pkg::*;

    // Handshake: a burst is accepted on a cycle with avm_read=1 and avm_waitrequest=0;
    // until then the master holds avm_read, avm_address and avm_burstcount stable.
    // Each cycle with avm_readdatavalid=1 carries one word of the single outstanding burst.
    logic [31:0]       avm_address;
    logic              avm_read;
    logic [3:0]        avm_burstcount;
    logic              avm_waitrequest;
    logic [WORD_W-1:0] avm_readdata;
    logic              avm_readdatavalid;

    modport master (
        output avm_address, avm_read, avm_burstcount,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );

    modport slave (
        input  avm_address, avm_read, avm_burstcount,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );

endinterface

// File: rtl/fb_word_fifo.sv
// Synchronous word FIFO with flush; dout shows the head word whenever not empty.
module fb_word_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WORD_W-1:0]      din,
    input  logic                   pop,
    output logic [WORD_W-1:0]      dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] free_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign free_cnt = (AW+1)'(DEPTH) - count_q;
    assign dout     = mem_q[rd_ptr_q];

    always_comb begin
        // A full FIFO may still accept a push in the cycle it pops.
        do_push  = push && !flush && (!full || pop);
        do_pop   = pop && !flush && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/fb_scanout_reader.sv
// Fetches one frame of packed 8-bit iteration indices from SDRAM in raster order
// and hands them out one pixel per pix_req to the VGA colour stage.
module fb_scanout_reader
    import fb_pkg::*;
#(
    parameter int          H_ACTIVE   = 640,
    parameter int          V_ACTIVE   = 480,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          BURST_LEN  = 8,
    parameter int          FIFO_DEPTH = 64
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic                frame_start,
    fb_scanout_reader_if.master avm,
    input  logic                pix_req,
    output logic [PIX_W-1:0]    pix_data,
    output logic                pix_valid,
    output logic                underflow,
    output logic                frame_done,
    output state_t              dbg_state
);
    localparam int FRAME_WORDS = frame_words(H_ACTIVE, V_ACTIVE);
    localparam int NBURSTS     = FRAME_WORDS / BURST_LEN;
    localparam int BW          = $clog2(NBURSTS + 1);
    localparam int RW          = $clog2(BURST_LEN + 1);
    localparam int FW          = $clog2(FIFO_DEPTH);

    localparam logic [BW-1:0] NB_LAST   = BW'(NBURSTS);
    localparam logic [RW-1:0] RCV_LAST  = RW'(BURST_LEN - 1);
    localparam logic [31:0]   ADDR_STEP = 32'(2 * BURST_LEN);

    if (((H_ACTIVE * V_ACTIVE) % 2 != 0) || (FRAME_WORDS % BURST_LEN != 0) ||
        (BURST_LEN > 15) || (FIFO_DEPTH != (1 << FW)) || (FIFO_DEPTH < 2 * BURST_LEN)) begin : g_bad_cfg
        $error("fb_scanout_reader: frame must split into whole words and bursts, FIFO_DEPTH a power of two >= 2*BURST_LEN");
    end

    state_t            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [BW-1:0]     bursts_q, bursts_d;
    logic [RW-1:0]     rcv_q, rcv_d;
    logic              half_q, half_d;
    logic              underflow_q, underflow_d;
    logic [PIX_W-1:0]  pix_data_q, pix_data_d;
    logic              pix_valid_q, pix_valid_d;
    logic              frame_done_q, frame_done_d;

    logic              fifo_push, fifo_pop;
    logic [WORD_W-1:0] fifo_dout;
    logic              fifo_empty, fifo_full;
    logic [FW:0]       fifo_free;

    fb_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .flush         (frame_start),
        .push          (fifo_push),
        .din           (avm.avm_readdata),
        .pop           (fifo_pop),
        .dout          (fifo_dout),
        .empty         (fifo_empty),
        .full          (fifo_full),
        .free_cnt      (fifo_free)
    );

    always_comb begin
        state_d            = state_q;
        addr_d             = addr_q;
        bursts_d           = bursts_q;
        rcv_d              = rcv_q;
        frame_done_d       = 1'b0;
        fifo_push          = 1'b0;
        avm.avm_read       = 1'b0;
        avm.avm_address    = '0;
        avm.avm_burstcount = '0;
        case (state_q)
            IDLE: if (frame_start) state_d = CHECK;
            CHECK: begin
                if (frame_start)                           state_d = CHECK;
                else if (bursts_q == NB_LAST)              state_d = IDLE;
                else if (fifo_free >= (FW+1)'(BURST_LEN))  state_d = ISSUE;
            end
            ISSUE: begin
                avm.avm_read       = 1'b1;
                avm.avm_address    = addr_q;
                avm.avm_burstcount = 4'(BURST_LEN);
                if (!avm.avm_waitrequest) begin
                    rcv_d = '0;
                    // An accepted burst must be drained even when the frame restarts.
                    if (frame_start) state_d = DISCARD;
                    else begin
                        addr_d   = addr_q + ADDR_STEP;
                        bursts_d = bursts_q + 1'b1;
                        state_d  = COLLECT;
                    end
                end else if (frame_start) begin
                    state_d = CHECK;
                end
            end
            COLLECT: begin
                if (avm.avm_readdatavalid) begin
                    rcv_d     = rcv_q + 1'b1;
                    fifo_push = !frame_start;
                    if (rcv_q == RCV_LAST && !frame_start) begin
                        state_d      = CHECK;
                        frame_done_d = (bursts_q == NB_LAST);
                    end
                end
                if (frame_start)
                    state_d = (avm.avm_readdatavalid && rcv_q == RCV_LAST) ? CHECK : DISCARD;
            end
            DISCARD: begin
                if (avm.avm_readdatavalid) begin
                    rcv_d = rcv_q + 1'b1;
                    if (rcv_q == RCV_LAST) state_d = CHECK;
                end
            end
            default: state_d = IDLE;
        endcase
        if (frame_start) begin
            addr_d   = BASE_ADDR;
            bursts_d = '0;
        end
    end

    // Unpacker: low byte first, the FIFO word is popped with the high byte.
    always_comb begin
        pix_valid_d = 1'b0;
        pix_data_d  = '0;
        half_d      = half_q;
        underflow_d = underflow_q;
        fifo_pop    = 1'b0;
        if (frame_start) begin
            half_d      = 1'b0;
            underflow_d = 1'b0;
        end else if (pix_req) begin
            if (!fifo_empty) begin
                pix_valid_d = 1'b1;
                pix_data_d  = half_q ? fifo_dout[WORD_W-1:PIX_W] : fifo_dout[PIX_W-1:0];
                half_d      = ~half_q;
                fifo_pop    = half_q;
            end else begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q      <= IDLE;
            addr_q       <= BASE_ADDR;
            bursts_q     <= '0;
            rcv_q        <= '0;
            half_q       <= 1'b0;
            underflow_q  <= 1'b0;
            pix_data_q   <= '0;
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            bursts_q     <= bursts_d;
            rcv_q        <= rcv_d;
            half_q       <= half_d;
            underflow_q  <= underflow_d;
            pix_data_q   <= pix_data_d;
            pix_valid_q  <= pix_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // CHECK only issues a burst when a whole burst fits, so this never fires.
    assert property (@(posedge clk_clk) disable iff (!reset_reset_n)
                     !(fifo_push && fifo_full && !fifo_pop));

    assign pix_data   = pix_data_q;
    assign pix_valid  = pix_valid_q;
    assign underflow  = underflow_q;
    assign frame_done = frame_done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Directed bench for fb_scanout_reader: default-geometry instance plus a 16x2 full-frame instance.
module tb_fb_scanout_reader;
  import fb_pkg::*;

  logic clk_clk = 1'b0;
  always #10 clk_clk = ~clk_clk;

  logic       reset_reset_n;
  logic       frame_start, pix_req, frame_start_s, pix_req_s;
  logic [7:0] pix_data, pix_data_s;
  logic       pix_valid, underflow, frame_done;
  logic       pix_valid_s, underflow_s, frame_done_s;
  state_t     dbg_state, dbg_state_s;

  int tests_run = 0;
  int tests_failed = 0;

  fb_scanout_reader_if bus ();
  fb_scanout_reader_if bus_s ();

  fb_scanout_reader dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .frame_start(frame_start), .avm(bus.master),
    .pix_req(pix_req), .pix_data(pix_data), .pix_valid(pix_valid), .underflow(underflow),
    .frame_done(frame_done), .dbg_state(dbg_state)
  );

  fb_scanout_reader #(.H_ACTIVE(16), .V_ACTIVE(2)) dut_s (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .frame_start(frame_start_s), .avm(bus_s.master),
    .pix_req(pix_req_s), .pix_data(pix_data_s), .pix_valid(pix_valid_s), .underflow(underflow_s),
    .frame_done(frame_done_s), .dbg_state(dbg_state_s)
  );

  function automatic logic [15:0] mem_word(input logic [31:0] n);
    return {n[6:0], 1'b1, n[6:0], 1'b0};
  endfunction

  // Memory models: one outstanding 8-word burst, first word sampled 3 cycles after acceptance.
  int          rem = 0, lat = 0, acc_cnt = 0;
  logic [31:0] word_idx = '0;
  logic [31:0] acc_addr_q[$];
  int          rem_s = 0, lat_s = 0, acc_cnt_s = 0;
  logic [31:0] word_idx_s = '0;

  always @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      rem = 0; lat = 0;
      bus.avm_readdatavalid <= 1'b0;
      bus.avm_readdata <= '0;
    end else begin
      if (rem > 0 && lat > 0) begin
        lat--; bus.avm_readdatavalid <= 1'b0;
      end else if (rem > 0) begin
        bus.avm_readdatavalid <= 1'b1; bus.avm_readdata <= mem_word(word_idx);
        word_idx++; rem--;
      end else bus.avm_readdatavalid <= 1'b0;
      if (bus.avm_read && !bus.avm_waitrequest) begin
        acc_cnt++; acc_addr_q.push_back(bus.avm_address);
        rem = 8; lat = 1; word_idx = bus.avm_address >> 1;
      end
    end
  end

  always @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      rem_s = 0; lat_s = 0;
      bus_s.avm_readdatavalid <= 1'b0;
      bus_s.avm_readdata <= '0;
    end else begin
      if (rem_s > 0 && lat_s > 0) begin
        lat_s--; bus_s.avm_readdatavalid <= 1'b0;
      end else if (rem_s > 0) begin
        bus_s.avm_readdatavalid <= 1'b1; bus_s.avm_readdata <= mem_word(word_idx_s);
        word_idx_s++; rem_s--;
      end else bus_s.avm_readdatavalid <= 1'b0;
      if (bus_s.avm_read && !bus_s.avm_waitrequest) begin
        acc_cnt_s++; rem_s = 8; lat_s = 1; word_idx_s = bus_s.avm_address >> 1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests_run=%0d required completion", tests_run);
    $fatal(1);
  end

  task automatic do_reset;
    @(negedge clk_clk);
    reset_reset_n = 1'b0;
    frame_start = 1'b0; pix_req = 1'b0; frame_start_s = 1'b0; pix_req_s = 1'b0;
    bus.avm_waitrequest = 1'b0; bus_s.avm_waitrequest = 1'b0;
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
  endtask

  task automatic pulse_fs;
    frame_start = 1'b1;
    @(negedge clk_clk);
    frame_start = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    tests_run++; if (bus.avm_read !== 1'b0) begin tests_failed++; $display("FAIL reset_read: got %b want 0", bus.avm_read); end
    tests_run++; if (bus.avm_address !== 32'h0) begin tests_failed++; $display("FAIL reset_addr: got %h want 0", bus.avm_address); end
    tests_run++; if (bus.avm_burstcount !== 4'd0) begin tests_failed++; $display("FAIL reset_bc: got %0d want 0", bus.avm_burstcount); end
    tests_run++; if ({pix_valid, pix_data} !== 9'h0) begin tests_failed++; $display("FAIL reset_pix: got %b/%h want 0/00", pix_valid, pix_data); end
    tests_run++; if ({underflow, frame_done} !== 2'b00) begin tests_failed++; $display("FAIL reset_flags: got uf=%b fd=%b want 0/0", underflow, frame_done); end
    tests_run++; if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
  endtask

  task automatic test_basic;
    int base, t;
    do_reset;
    base = acc_addr_q.size();
    pulse_fs;
    t = 0;
    while (acc_addr_q.size() < base + 4 && t < 500) begin @(negedge clk_clk); t++; end
    tests_run++;
    if (acc_addr_q.size() < base + 4) begin tests_failed++; $display("FAIL basic_bursts: got %0d bursts want 4", acc_addr_q.size() - base); end
    for (int i = 0; i < 4 && base + i < acc_addr_q.size(); i++) begin
      tests_run++;
      if (acc_addr_q[base + i] !== 32'(i * 16)) begin tests_failed++; $display("FAIL basic_addr%0d: got %h want %h", i, acc_addr_q[base + i], i * 16); end
    end
    repeat (10) @(negedge clk_clk);
    pix_req = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_clk);
      if (k == 39) pix_req = 1'b0;
      tests_run++;
      if ({pix_valid, pix_data} !== {1'b1, 8'(k)}) begin tests_failed++; $display("FAIL basic_pix%0d: got %b/%h want 1/%h", k, pix_valid, pix_data, 8'(k)); end
    end
  endtask

  task automatic test_waitrequest;
    int base, t;
    do_reset;
    bus.avm_waitrequest = 1'b1;
    base = acc_cnt;
    pulse_fs;
    t = 0;
    while (!bus.avm_read && t < 20) begin @(negedge clk_clk); t++; end
    tests_run++;
    if (bus.avm_read !== 1'b1) begin tests_failed++; $display("FAIL wait_read_seen: got %b want 1", bus.avm_read); end
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if ({bus.avm_read, bus.avm_address, bus.avm_burstcount} !== {1'b1, 32'h0, 4'd8}) begin
        tests_failed++; $display("FAIL wait_hold%0d: got rd=%b a=%h bc=%0d want 1/0/8", i, bus.avm_read, bus.avm_address, bus.avm_burstcount);
      end
      if (i == 5) bus.avm_waitrequest = 1'b0;
      @(negedge clk_clk);
    end
    tests_run++; if (bus.avm_read !== 1'b0) begin tests_failed++; $display("FAIL wait_deassert: got %b want 0", bus.avm_read); end
    repeat (2) @(negedge clk_clk);
    tests_run++; if (acc_cnt - base !== 1) begin tests_failed++; $display("FAIL wait_accepts: got %0d want 1", acc_cnt - base); end
  endtask

  task automatic test_fill_park;
    int base;
    do_reset;
    base = acc_cnt;
    pulse_fs;
    repeat (300) @(negedge clk_clk);
    tests_run++; if (acc_cnt - base !== 8) begin tests_failed++; $display("FAIL park_bursts: got %0d want 8", acc_cnt - base); end
    tests_run++; if (bus.avm_read !== 1'b0) begin tests_failed++; $display("FAIL park_read: got %b want 0", bus.avm_read); end
    tests_run++; if (dbg_state !== CHECK) begin tests_failed++; $display("FAIL park_state: got %0d want CHECK", dbg_state); end
    pix_req = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_clk);
      if (k == 15) pix_req = 1'b0;
      tests_run++;
      if ({pix_valid, pix_data} !== {1'b1, 8'(k)}) begin tests_failed++; $display("FAIL park_pix%0d: got %b/%h want 1/%h", k, pix_valid, pix_data, 8'(k)); end
    end
    repeat (100) @(negedge clk_clk);
    tests_run++; if (acc_cnt - base !== 9) begin tests_failed++; $display("FAIL refill_bursts: got %0d want 9", acc_cnt - base); end
    tests_run++; if (acc_addr_q[$] !== 32'h80) begin tests_failed++; $display("FAIL refill_addr: got %h want 80", acc_addr_q[$]); end
    tests_run++; if (dbg_state !== CHECK) begin tests_failed++; $display("FAIL refill_state: got %0d want CHECK", dbg_state); end
  endtask

  task automatic test_underflow;
    do_reset;
    pulse_fs;
    pix_req = 1'b1;
    @(negedge clk_clk);
    pix_req = 1'b0;
    tests_run++; if ({pix_valid, pix_data} !== 9'h0) begin tests_failed++; $display("FAIL uf_pix: got %b/%h want 0/00", pix_valid, pix_data); end
    tests_run++; if (underflow !== 1'b1) begin tests_failed++; $display("FAIL uf_set: got %b want 1", underflow); end
    repeat (30) @(negedge clk_clk);
    tests_run++; if (underflow !== 1'b1) begin tests_failed++; $display("FAIL uf_sticky: got %b want 1", underflow); end
    frame_start = 1'b1; pix_req = 1'b1;
    @(negedge clk_clk);
    frame_start = 1'b0; pix_req = 1'b0;
    tests_run++; if (underflow !== 1'b0) begin tests_failed++; $display("FAIL uf_clear: got %b want 0", underflow); end
    tests_run++; if (pix_valid !== 1'b0) begin tests_failed++; $display("FAIL uf_flush_wins: got %b want 0", pix_valid); end
  endtask

  task automatic test_discard;
    int base, seen, t;
    do_reset;
    base = acc_addr_q.size();
    pulse_fs;
    seen = 0; t = 0;
    while (seen < 3 && t < 50) begin
      @(negedge clk_clk); t++;
      if (bus.avm_readdatavalid) seen++;
    end
    @(negedge clk_clk);
    pulse_fs;
    t = 0;
    while (acc_addr_q.size() < base + 2 && t < 100) begin @(negedge clk_clk); t++; end
    tests_run++;
    if (acc_addr_q.size() !== base + 2) begin tests_failed++; $display("FAIL disc_bursts: got %0d want 2", acc_addr_q.size() - base); end
    else begin
      tests_run++;
      if (acc_addr_q[base + 1] !== 32'h0) begin tests_failed++; $display("FAIL disc_restart_addr: got %h want 0", acc_addr_q[base + 1]); end
    end
    pix_req = 1'b1;
    @(negedge clk_clk);
    pix_req = 1'b0;
    tests_run++; if (pix_valid !== 1'b0) begin tests_failed++; $display("FAIL disc_fifo_empty: got valid=%b data=%h want 0", pix_valid, pix_data); end
    repeat (15) @(negedge clk_clk);
    pix_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_clk);
      if (k == 1) pix_req = 1'b0;
      tests_run++;
      if ({pix_valid, pix_data} !== {1'b1, 8'(k)}) begin tests_failed++; $display("FAIL disc_pix%0d: got %b/%h want 1/%h", k, pix_valid, pix_data, 8'(k)); end
    end
  endtask

  task automatic test_full_frame;
    int base, k, fd;
    do_reset;
    base = acc_cnt_s;
    frame_start_s = 1'b1;
    @(negedge clk_clk);
    frame_start_s = 1'b0;
    pix_req_s = 1'b1;
    k = 0; fd = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk_clk);
      if (frame_done_s) fd++;
      if (pix_valid_s) begin
        tests_run++;
        if (pix_data_s !== 8'(k)) begin tests_failed++; $display("FAIL frame_pix%0d: got %h want %h", k, pix_data_s, 8'(k)); end
        k++;
      end
    end
    pix_req_s = 1'b0;
    tests_run++; if (k !== 32) begin tests_failed++; $display("FAIL frame_pix_count: got %0d want 32", k); end
    tests_run++; if (fd !== 1) begin tests_failed++; $display("FAIL frame_done_count: got %0d want 1", fd); end
    tests_run++; if (dbg_state_s !== IDLE) begin tests_failed++; $display("FAIL frame_state: got %0d want IDLE", dbg_state_s); end
    tests_run++; if (acc_cnt_s - base !== 2) begin tests_failed++; $display("FAIL frame_bursts: got %0d want 2", acc_cnt_s - base); end
  endtask

  initial begin
    reset_reset_n = 1'b0;
    frame_start = 1'b0; pix_req = 1'b0; frame_start_s = 1'b0; pix_req_s = 1'b0;
    bus.avm_waitrequest = 1'b0; bus_s.avm_waitrequest = 1'b0;
    test_reset;
    test_basic;
    test_waitrequest;
    test_fill_park;
    test_underflow;
    test_discard;
    test_full_frame;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fb_scanout_reader.md
Name: fb_scanout_reader

Overview:
- Read side of the SDRAM framebuffer that fractal_calc fills through the bitmap draw/x/y/i write path.
- An Avalon-MM burst read master fetches packed 8-bit iteration indices (two per 16-bit SDRAM word) in raster order into a word FIFO.
- An unpacker hands one pixel per request to the VGA colour-mapping logic.
- Sits inside the vga_interface component, between the SDRAM controller port and the VGA timing/palette stage.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- BASE_ADDR, 32'h0, byte address of pixel (0,0)
- BURST_LEN, 8, 16-bit words per read burst
- FIFO_DEPTH, 64, FIFO depth in words (power of two, >= 2*BURST_LEN)

Ports:
- clk_clk  in  1  system clock, 50 MHz
- reset_reset_n  in  1  synchronous, active-low reset
- frame_start  in  1  one-cycle pulse from VGA timing at end of vsync; restarts the frame
- avm_address  out  32  byte address of burst
- avm_read  out  1  read request
- avm_burstcount  out  4  burst length (= BURST_LEN)
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  16  two pixels: [7:0] = even x, [15:8] = odd x
- avm_readdatavalid  in  1  readdata strobe
- pix_req  in  1  consumer pops one pixel (asserted only in active video)
- pix_data  out  8  iteration index of popped pixel
- pix_valid  out  1  pix_data valid (registered)
- underflow  out  1  sticky: a pix_req found no data this frame
- frame_done  out  1  one-cycle pulse when the last word of the frame has been received

Behaviour:
- Reset values: every output 0; FSM = IDLE; FIFO empty; address = BASE_ADDR; word and burst counters 0; half-select 0.
- FRAME_WORDS = H_ACTIVE*V_ACTIVE/2 (153600 at the defaults). NBURSTS = FRAME_WORDS/BURST_LEN. Both must be exact integers; elaboration fails otherwise.
- State IDLE: wait for frame_start. Then load addr = BASE_ADDR, clear bursts_issued, flush FIFO, clear underflow, go to CHECK.
- State CHECK:
  - If bursts_issued == NBURSTS, go to IDLE.
  - Else if FIFO free space >= BURST_LEN, go to ISSUE.
  - Else stay in CHECK.
- State ISSUE:
  - Drive avm_read=1, avm_address=addr, avm_burstcount=BURST_LEN.
  - Hold all three stable while avm_waitrequest=1.
  - On the cycle avm_waitrequest=0: deassert read next cycle, addr += 2*BURST_LEN, bursts_issued++, rcv_cnt=0, go to COLLECT.
- State COLLECT:
  - Each avm_readdatavalid pushes avm_readdata into the FIFO and increments rcv_cnt.
  - When rcv_cnt reaches BURST_LEN, go to CHECK. The last burst of the frame pulses frame_done on the cycle after its final word.
- At most one burst is outstanding. FIFO overflow is impossible by construction; it is asserted in simulation.
- Unpacker:
  - On pix_req with data available: pix_data = current word's byte[half], pix_valid=1 on the next cycle (latency 1), then half toggles.
  - Popping the high byte (half=1) pops the FIFO word.
  - Pixel order within a word: low byte, then high byte.
- Underflow: on pix_req with the FIFO empty, the next cycle gives pix_valid=0 and pix_data=8'h00, underflow is set, and half is not advanced.
- FIFO push and pop in the same cycle are both honoured, including when the FIFO is full and popping, or empty and pushing. The pushed word is not readable until the following cycle.
- frame_start mid-frame:
  - In CHECK or ISSUE before acceptance: abort immediately and restart.
  - In ISSUE after acceptance, or in COLLECT: enter DISCARD. DISCARD swallows the remaining (BURST_LEN - rcv_cnt) readdatavalid words without pushing them, then restarts as from IDLE.
  - The FIFO is flushed and half reset in the same cycle frame_start is seen.
- frame_start coincident with pix_req: the flush wins, and that pix_req counts as underflow only if it occurs after the flush.
- Reset mid-burst: return to the reset state at once. Any later stray readdatavalid arriving in IDLE is ignored.

Decomposition:
- Package fb_pkg:
  - state_t enum (IDLE, CHECK, ISSUE, COLLECT, DISCARD)
  - PIX_W=8, WORD_W=16
  - function frame_words(h,v)
- Sub-module fb_word_fifo: synchronous FIFO, WORD_W x FIFO_DEPTH. Ports: clk_clk, reset_reset_n, flush, push, din, pop, dout, empty, full, free_cnt (log2(FIFO_DEPTH)+1 bits).

Test Plan:
- Reset, then frame_start, with waitrequest=0, fixed readdatavalid latency 3, and a memory model holding word n = {n[6:0],1'b1, n[6:0],1'b0} (odd byte, even byte). Expect avm_address sequence 0x0, 0x10, 0x20, …, and pix_data for pixel k equal to the low byte for even k and the high byte for odd k, one cycle after each pix_req.
- Hold avm_waitrequest=1 for 5 cycles on the first burst. Expect avm_address, avm_read and avm_burstcount=8 stable for all 6 cycles, and exactly one burst accepted.
- No pix_req after frame_start. Expect exactly 8 bursts issued (64 words), then the FSM parked in CHECK with avm_read=0. One 16-pixel pop (8 words freed) must trigger exactly one new burst.
- pix_req asserted continuously from the cycle after frame_start, before any data arrives. Expect pix_valid=0, pix_data=0x00 and underflow=1. The next frame_start must clear underflow.
- Assert frame_start when rcv_cnt=3 in COLLECT. Expect the remaining 5 words discarded (FIFO stays empty), then a new burst at BASE_ADDR, and first pix_data = word0 low byte.
- Full small frame (H_ACTIVE=16, V_ACTIVE=2; 16 words = 2 bursts) with continuous pops. Expect frame_done pulsed once after word 16, the FSM in IDLE, and 32 valid pixels delivered in order.
